rr_decode_scheduler: RTL and testbench

- Round-robin scheduler that shares a single 4-to-16 one-hot select decoder among 16 requesters.
- Arbitrates the `req` lines and drives the decoder's 4-bit select index and enable.
- Holds each grant until the owner signals `done`, drops its request, or hits a hold-time limit.
- Sits directly upstream of the decoder; the decoder's one-hot output is the per-requester grant strobe.

---
 rtl/rr_sched_pkg.sv | 13 +
 rtl/rr_decode_scheduler_if.sv | 31 +++
 rtl/rr_pick.sv | 34 +++
 rtl/rr_decode_scheduler.sv | 107 ++++++++++
 tb/tb_rr_decode_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin decode scheduler and its picker.
package rr_sched_pkg;

  localparam int IDX_W   = 4;
  localparam int NUM_REQ = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_decode_scheduler_if.sv
// Request/grant bundle between the requesters and the scheduler.
// The scheduler side uses the slave modport; the requester side uses master.
interface rr_decode_scheduler_if;
  import rr_sched_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_en;
  logic               busy;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  grant_idx,
    input  grant_en,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_idx,
    output grant_en,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: finds the first set request bit
// at or above ptr, wrapping from the top index back to 0.
module rr_pick
  import rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // rot[k] is the request that sits k positions above ptr (modulo NUM_REQ)
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   offset;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req[ptr + IDX_W'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the winner; add ptr back to un-rotate
  always_comb begin
    found  = |rot;
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = IDX_W'(k);
      end
    end
    idx = ptr + offset;
  end

endmodule

// File: rtl/rr_decode_scheduler.sv
// Round-robin owner of a shared 4-to-16 one-hot decoder. Drives the decoder
// select/enable, holds each grant until done, request drop or hold expiry,
// and inserts one dead cycle between grants (break-before-make).
module rr_decode_scheduler
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_decode_scheduler_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  sched_state_e       state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic               grant_en_reg, grant_en_next;
  logic               busy_reg, busy_next;
  logic               timeout_reg, timeout_next;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_release;
  logic               hold_expired;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_release = bus.done | ~bus.req[grant_idx_reg];
  assign hold_expired  = (hold_reg == HOLD_LAST);

  // Next-state logic: arbitration, hold counting and release handling
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_idx_next = grant_idx_reg;
    hold_next      = hold_reg;
    timeout_next   = 1'b0;

    case (state_reg)
      // GAP is already the dead cycle, so it arbitrates with the fresh
      // pointer; that keeps the spacing between grants at one cycle.
      IDLE, GAP: begin
        if (pick_found) begin
          state_next     = GRANT;
          grant_idx_next = pick_idx;
          hold_next      = '0;
        end else begin
          state_next = IDLE;
        end
      end

      GRANT: begin
        if (owner_release || hold_expired) begin
          state_next   = GAP;
          ptr_next     = grant_idx_reg + 1'b1;
          // Expiry only counts as a timeout when the owner did not release too
          timeout_next = ~owner_release;
        end else if (hold_reg != HOLD_LAST) begin
          hold_next = hold_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    grant_en_next = (state_next == GRANT);
    busy_next     = (state_next != IDLE);
  end

  // State and registered outputs; reset aborts any grant in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_idx_reg <= '0;
      hold_reg      <= '0;
      grant_en_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_idx_reg <= grant_idx_next;
      hold_reg      <= hold_next;
      grant_en_reg  <= grant_en_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign bus.grant_idx = grant_idx_reg;
  assign bus.grant_en  = grant_en_reg;
  assign bus.busy      = busy_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_decode_scheduler.sv
// Scoreboard bench for rr_decode_scheduler: directed stimulus pushes the
// expected grant records, a negedge monitor pops one per grant release.
module tb_rr_decode_scheduler;
  import rr_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;

  rr_decode_scheduler_if bus_if ();

  rr_decode_scheduler #(
    .MAX_HOLD (8),
    .HOLD_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // idx: owner; len: cycles grant_en was high; to: timeout in the dead cycle;
  // gap: dead cycles before this grant (-1 = don't care);
  // kept: normal release, so grant_idx must hold and busy must be high
  typedef struct {
    int idx;
    int len;
    int to;
    int gap;
    bit kept;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int idx, input int len, input int to,
                              input int gap, input bit kept);
    ev_t e;
    e.idx  = idx;
    e.len  = len;
    e.to   = to;
    e.gap  = gap;
    e.kept = kept;
    exp_q.push_back(e);
  endtask

  // Called right after the edge where a grant starts; done is sampled on
  // the k-th following edge, so the grant lasts k cycles.
  task automatic pulse_done(input int k);
    if (k > 1) tick(k - 1);
    bus_if.done = 1'b1;
    tick(1);
    bus_if.done = 1'b0;
  endtask

  // Monitor: tracks each grant run and checks it against the scoreboard on release
  initial begin : monitor
    bit  prev_en;
    int  run_idx, run_len, run_gap, dead;
    ev_t e;
    prev_en = 1'b0;
    run_idx = 0;
    run_len = 0;
    run_gap = 0;
    dead    = 0;
    forever begin
      @(negedge clk);
      if (bus_if.grant_en === 1'b1) begin
        if (!prev_en) begin
          run_idx = int'(bus_if.grant_idx);
          run_len = 1;
          run_gap = dead;
        end else begin
          run_len++;
          check("idx_stable", int'(bus_if.grant_idx), run_idx);
        end
        check("timeout_in_grant", int'(bus_if.timeout), 0);
      end else begin
        if (prev_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got idx %0d len %0d, required none", run_idx, run_len);
          end else begin
            e = exp_q.pop_front();
            $display("grant idx=%0d len=%0d timeout=%0d gap=%0d", run_idx, run_len, bus_if.timeout, run_gap);
            check("grant_idx", run_idx, e.idx);
            check("grant_len", run_len, e.len);
            check("timeout", int'(bus_if.timeout), e.to);
            if (e.gap >= 0) check("gap", run_gap, e.gap);
            if (e.kept) begin
              check("idx_kept_in_gap", int'(bus_if.grant_idx), e.idx);
              check("busy_in_gap", int'(bus_if.busy), 1);
            end
          end
          dead = 1;
        end else begin
          dead++;
          check("timeout_idle", int'(bus_if.timeout), 0);
        end
      end
      prev_en = (bus_if.grant_en === 1'b1);
    end
  end

  // Stimulus
  initial begin
    reset       = 1'b1;
    bus_if.req  = '0;
    bus_if.done = 1'b0;
    tick(2);
    check("rst_grant_en", int'(bus_if.grant_en), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_grant_idx", int'(bus_if.grant_idx), 0);
    check("rst_timeout", int'(bus_if.timeout), 0);
    reset = 1'b0;

    // No requests: stay idle
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("idle_grant_en", int'(bus_if.grant_en), 0);
      check("idle_busy", int'(bus_if.busy), 0);
      check("idle_grant_idx", int'(bus_if.grant_idx), 0);
    end

    // 0x0024 from ptr 0: grant 2, done, then grant 5 from ptr 3
    expect_grant(2, 2, 0, -1, 1);
    expect_grant(5, 3, 0, 1, 1);
    bus_if.req = 16'h0024;
    tick(1);
    check("lat_grant_en", int'(bus_if.grant_en), 1);
    check("lat_grant_idx", int'(bus_if.grant_idx), 2);
    pulse_done(2);
    check("gap_grant_en", int'(bus_if.grant_en), 0);
    check("gap_busy", int'(bus_if.busy), 1);
    tick(1);
    check("next_grant_idx", int'(bus_if.grant_idx), 5);
    tick(2);
    bus_if.req = '0;
    tick(3);

    // 0x8001 from ptr 6: alternate 15, 0, 15, 0 across the wrap
    expect_grant(15, 2, 0, -1, 1);
    expect_grant(0, 2, 0, 1, 1);
    expect_grant(15, 2, 0, 1, 1);
    expect_grant(0, 2, 0, 1, 1);
    bus_if.req = 16'h8001;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      pulse_done(2);
      if (i < 3) tick(1);
    end
    bus_if.req = '0;
    tick(2);

    // Lone requester 4 held with no done: 8-cycle grant, timeout, re-grant
    expect_grant(4, 8, 1, -1, 1);
    expect_grant(4, 1, 0, 1, 1);
    bus_if.req = 16'h0010;
    tick(1);
    tick(8);
    check("expiry_timeout", int'(bus_if.timeout), 1);
    check("expiry_grant_en", int'(bus_if.grant_en), 0);
    tick(1);
    check("regrant_idx", int'(bus_if.grant_idx), 4);
    check("regrant_en", int'(bus_if.grant_en), 1);
    pulse_done(1);
    bus_if.req = '0;
    tick(2);

    // Grant 3 (wrap from ptr 5): done and request drop together
    expect_grant(3, 2, 0, -1, 1);
    bus_if.req = 16'h0008;
    tick(2);
    bus_if.done = 1'b1;
    bus_if.req  = '0;
    tick(1);
    bus_if.done = 1'b0;
    check("dual_busy_gap", int'(bus_if.busy), 1);
    check("dual_timeout", int'(bus_if.timeout), 0);
    tick(1);
    check("dual_busy_after", int'(bus_if.busy), 0);
    check("dual_grant_en_after", int'(bus_if.grant_en), 0);
    tick(1);

    // Grant 6: done coincides with hold expiry, so no timeout
    expect_grant(6, 8, 0, -1, 1);
    bus_if.req = 16'h0040;
    tick(1);
    tick(7);
    bus_if.done = 1'b1;
    tick(1);
    bus_if.done = 1'b0;
    check("done_at_expiry_timeout", int'(bus_if.timeout), 0);
    bus_if.req = '0;
    tick(2);

    // Reset in the middle of a grant to 9; pointer returns to 0
    expect_grant(9, 3, 0, -1, 0);
    expect_grant(0, 2, 0, -1, 1);
    bus_if.req = 16'h0200;
    tick(1);
    check("pre_rst_idx", int'(bus_if.grant_idx), 9);
    tick(2);
    reset      = 1'b1;
    bus_if.req = 16'h0201;
    tick(1);
    check("mid_rst_grant_en", int'(bus_if.grant_en), 0);
    check("mid_rst_busy", int'(bus_if.busy), 0);
    reset = 1'b0;
    tick(1);
    check("post_rst_grant_en", int'(bus_if.grant_en), 1);
    check("post_rst_grant_idx", int'(bus_if.grant_idx), 0);
    pulse_done(2);
    bus_if.req = '0;
    tick(4);

    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
